// File: rtl/approx_mul_seq_if.sv
// Operand/result handshake bundle for approx_mul_seq.
// The source/sink side uses master; the multiplier uses slave.
interface approx_mul_seq_if #(
   parameter int N = 8
) ();
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           mode;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] c;

   modport master (
      output in_valid, a, b, mode, out_ready,
      input  in_ready, out_valid, c
   );

   modport slave (
      input  in_valid, a, b, mode, out_ready,
      output in_ready, out_valid, c
   );
endinterface

// File: rtl/approx_mul_seq.sv
// Sequential radix-2 shift-add N x N multiplier, one multiplier bit per clock.
// Approximate mode discards partial-product columns 0..K-1; op_count saturates.
module approx_mul_seq #(
   parameter int N  = 8,
   parameter int K  = 4,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   approx_mul_seq_if.slave bus,
   output logic          busy,
   output logic [CW-1:0] op_count
);
   localparam int W  = 2 * N;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   // K == W shifts the one out entirely, so every column is discarded.
   localparam logic [W-1:0] APPROX_MASK = ~((W'(1) << K) - W'(1));

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic          mode_q, mode_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  c_q, c_d;
   logic [CW-1:0] op_count_q, op_count_d;

   logic [W-1:0]  pp_full;
   logic [W-1:0]  pp;
   logic [W-1:0]  sum;

   always_comb begin
      pp_full = b_q[idx_q] ? (W'(a_q) << idx_q) : '0;
      pp      = mode_q ? (pp_full & APPROX_MASK) : pp_full;
      sum     = acc_q + pp;
   end

   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves a latch behind.
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      mode_d     = mode_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      c_d        = c_q;
      op_count_d = op_count_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               mode_d  = bus.mode;
               acc_d   = '0;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = sum;
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(N - 1)) begin
               c_d     = sum;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               if (op_count_q != {CW{1'b1}}) op_count_d = op_count_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
      if (rst) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         mode_q     <= 1'b0;
         acc_q      <= '0;
         idx_q      <= '0;
         c_q        <= '0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         mode_q     <= mode_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         c_q        <= c_d;
         op_count_q <= op_count_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.c         = c_q;
   assign busy          = (state_q != IDLE);
   assign op_count      = op_count_q;
endmodule

// File: tb/tb_approx_mul_seq.sv
// Directed and random checks of approx_mul_seq (N=8, K=4, CW=4) against an
// arithmetic reference of the exact/truncated-column product.
module tb_approx_mul_seq;
   localparam int N  = 8;
   localparam int K  = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          busy;
   logic [CW-1:0] op_count;
   int            tests_run = 0;
   int            tests_failed = 0;
   int            exp_count = 0;

   approx_mul_seq_if #(.N(N)) bus ();

   approx_mul_seq #(.N(N), .K(K), .CW(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .op_count (op_count)
   );

   always #5 clk = ~clk;

   // Sum over set multiplier bits of the shifted multiplicand, low K columns cleared in approx mode.
   function automatic int ref_mul(input int a, input int b, input bit approx);
      int mask;
      int total;
      mask  = approx ? ((32'hFFFF << K) & 32'hFFFF) : 32'hFFFF;
      total = 0;
      for (int i = 0; i < N; i++)
         if ((b >> i) & 1) total += (a * (2 ** i)) & mask;
      return total;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_op(input int a, input int b, input bit m);
      int n = 0;
      while (!bus.in_ready && n < 100) begin tick(); n++; end
      check("accept_wait", int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.a        = N'(a);
      bus.b        = N'(b);
      bus.mode     = m;
      tick();
      bus.in_valid = 1'b0;
      bus.a        = N'($urandom);
      bus.b        = N'($urandom);
      bus.mode     = 1'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 50) begin tick(); lat++; end
   endtask

   task automatic finish_op(output int c_obs);
      c_obs = int'(bus.c);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      if (exp_count < (2 ** CW) - 1) exp_count++;
   endtask

   task automatic run_op(input string tag, input int a, input int b, input bit m, input int exp);
      int lat;
      int c_obs;
      start_op(a, b, m);
      wait_done(lat);
      check({tag, "_latency"}, lat, N);
      finish_op(c_obs);
      check(tag, c_obs, exp);
   endtask

   initial begin
      int lat;
      int c_obs;
      int c_hold;
      int ra, rb;
      bit rm;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.mode      = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_c", int'(bus.c), 0);
      check("rst_op_count", int'(op_count), 0);
      rst = 1'b0;
      tick();

      // Exact reference case with latency and counter.
      start_op(143, 227, 1'b0);
      check("run_busy", int'(busy), 1);
      check("run_in_ready", int'(bus.in_ready), 0);
      wait_done(lat);
      check("exact_latency", lat, 8);
      finish_op(c_obs);
      check("exact_143x227", c_obs, 32461);
      check("op_count_after_1", int'(op_count), 1);
      check("post_hs_in_ready", int'(bus.in_ready), 1);
      check("post_hs_out_valid", int'(bus.out_valid), 0);
      check("c_retained", int'(bus.c), 32461);

      run_op("approx_143x227", 143, 227, 1'b1, 32432);
      run_op("approx_255x255", 255, 255, 1'b1, 64976);
      run_op("exact_255x255", 255, 255, 1'b0, 65025);
      run_op("exact_0x200", 0, 200, 1'b0, 0);
      run_op("approx_0x200", 0, 200, 1'b1, 0);
      run_op("exact_255x1", 255, 1, 1'b0, 255);
      run_op("approx_255x1", 255, 1, 1'b1, 240);
      run_op("exact_1x128", 1, 128, 1'b0, 128);
      run_op("approx_1x128", 1, 128, 1'b1, 128);
      check("op_count_after_10", int'(op_count), exp_count);

      // Backpressure: hold DONE for 5 cycles while a new operand is offered.
      start_op(143, 227, 1'b0);
      wait_done(lat);
      c_hold = int'(bus.c);
      check("bp_result", c_hold, 32461);
      bus.in_valid = 1'b1;
      bus.a        = N'(7);
      bus.b        = N'(9);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_out_valid", int'(bus.out_valid), 1);
         check("bp_in_ready", int'(bus.in_ready), 0);
         check("bp_c_stable", int'(bus.c), c_hold);
      end
      bus.in_valid = 1'b0;
      finish_op(c_obs);
      check("bp_in_ready_rise", int'(bus.in_ready), 1);
      check("bp_out_valid_fall", int'(bus.out_valid), 0);
      check("bp_op_count", int'(op_count), exp_count);

      // Reset in the middle of RUN discards the operation.
      start_op(255, 255, 1'b0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_count = 0;
      check("mid_rst_in_ready", int'(bus.in_ready), 1);
      check("mid_rst_out_valid", int'(bus.out_valid), 0);
      check("mid_rst_c", int'(bus.c), 0);
      check("mid_rst_op_count", int'(op_count), 0);
      run_op("after_rst_exact", 143, 227, 1'b0, ref_mul(143, 227, 1'b0));
      check("after_rst_op_count", int'(op_count), 1);

      // 20 consecutive random ops drive the 4-bit counter into saturation.
      for (int i = 0; i < 20; i++) begin
         ra = int'($urandom_range(0, 255));
         rb = int'($urandom_range(0, 255));
         rm = 1'($urandom);
         start_op(ra, rb, rm);
         wait_done(lat);
         finish_op(c_obs);
         check("rand_sat_c", c_obs, ref_mul(ra, rb, rm));
         check("rand_sat_count", int'(op_count), exp_count);
      end
      check("count_saturated", int'(op_count), 15);

      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 400; i++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            start_op(ra, rb, 1'(m));
            wait_done(lat);
            finish_op(c_obs);
            check(m == 0 ? "rand_exact" : "rand_approx", c_obs, ref_mul(ra, rb, 1'(m)));
         end
      end
      check("count_still_15", int'(op_count), 15);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
